// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Sums a frame of unsigned products arriving from an upstream multiplier and
// hands the frame total, beat count and overflow indication downstream over a
// valid/ready handshake. A two-state FSM alternates between accepting beats
// (ACCUM) and presenting one finished frame result (HOLD).
//
// Parameters
//   LENGTH  operand width of the upstream multiplier (in_prod is 2*LENGTH bits)
//   GUARD   accumulator guard bits; ACC_W = 2*LENGTH + GUARD
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   in_valid   upstream product beat present
//   in_ready   block accepts a beat this cycle (high in ACCUM)
//   in_prod    unsigned product, 2*LENGTH bits
//   in_last    final beat of the frame, qualified by in_valid
//   out_valid  frame result available (high in HOLD)
//   out_ready  downstream accepts the result
//   out_sum    frame sum, ACC_W bits
//   out_count  number of beats in the frame, saturating at 65535
//   out_ovf    frame sum exceeded 2^ACC_W-1
//
// Configuration
//   PRODUCT_ACCUMULATOR_SATURATE_EN  defined: the accumulator clamps to
//     2^ACC_W-1 on overflow for the rest of the frame. Undefined (default):
//     the accumulator wraps modulo 2^ACC_W. out_ovf is set in both builds.
// -----------------------------------------------------------------------------
module product_accumulator #(
  parameter  int LENGTH = 8,
  parameter  int GUARD  = 4,
  localparam int ACC_W  = 2 * LENGTH + GUARD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*LENGTH-1:0]   in_prod,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_sum,
  output logic [15:0]           out_count,
  output logic                  out_ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [15:0]        cnt;
  logic               ovf;
  // Set once the first beat of a frame has been taken; clear means the next
  // accepted beat loads rather than adds.
  logic               frame_open;

  logic               accept;
  logic [ACC_W:0]     sum_ext;
  logic [ACC_W-1:0]   acc_next;
  logic [15:0]        cnt_next;
  logic               ovf_next;

  // Handshake flags decode from the state register alone, so there is no
  // combinational path from any input to in_ready or out_valid.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  // One extra bit on the adder captures the carry out of ACC_W bits.
  assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(in_prod);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    acc_next = acc;
    cnt_next = cnt;
    ovf_next = ovf;
    if (!frame_open) begin
      // A single product cannot overflow: ACC_W exceeds 2*LENGTH by GUARD bits.
      acc_next = ACC_W'(in_prod);
      cnt_next = 16'd1;
      ovf_next = 1'b0;
    end else begin
      ovf_next = ovf | sum_ext[ACC_W];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      // Sticky flag keeps the accumulator pinned at full scale even when a
      // later zero product would not itself carry.
      acc_next = ovf_next ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
      acc_next = sum_ext[ACC_W-1:0];
`endif
      cnt_next = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ACCUM;
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      frame_open <= 1'b0;
      out_sum    <= '0;
      out_count  <= '0;
      out_ovf    <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc        <= acc_next;
            cnt        <= cnt_next;
            ovf        <= ovf_next;
            frame_open <= 1'b1;
            if (in_last) begin
              out_sum    <= acc_next;
              out_count  <= cnt_next;
              out_ovf    <= ovf_next;
              frame_open <= 1'b0;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          // Results stay frozen here; beats are not accepted because
          // in_ready is low.
          if (out_ready) begin
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//
// Self-checking bench for product_accumulator (LENGTH=8, GUARD=4, ACC_W=20).
// Expected frame results come from a reference model that totals the beats of
// a frame with plain wide arithmetic and derives count and overflow from that.
// Honours PRODUCT_ACCUMULATOR_SATURATE_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

  localparam int LENGTH = 8;
  localparam int GUARD  = 4;
  localparam int ACC_W  = 2 * LENGTH + GUARD;
  localparam longint MAX_SUM = (64'd1 << ACC_W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [2*LENGTH-1:0] in_prod = '0;
  logic                in_last = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [ACC_W-1:0]    out_sum;
  logic [15:0]         out_count;
  logic                out_ovf;

  int checks = 0;
  int errors = 0;

  // Beats of the frame currently being sent, and the model's expectation.
  int unsigned       beats[$];
  logic [ACC_W-1:0]  es;
  logic [15:0]       ec;
  logic              eo;

  product_accumulator #(.LENGTH(LENGTH), .GUARD(GUARD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Reference: the frame result is a function of the whole list of beats.
  task automatic model();
    longint total;
    total = 0;
    foreach (beats[i]) total += longint'(beats[i]);
    ec = (beats.size() > 65535) ? 16'hFFFF : 16'(beats.size());
    eo = (total > MAX_SUM);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    es = eo ? ACC_W'(MAX_SUM) : total[ACC_W-1:0];
`else
    es = total[ACC_W-1:0];
`endif
  endtask

  // Sends every beat in 'beats', in_last on the final one, with up to gap_max
  // idle cycles (in_valid low, junk data) before each beat. Returns #1 after
  // the edge that took the last beat.
  task automatic send_beats(input int gap_max);
    foreach (beats[i]) begin
      repeat ($urandom_range(gap_max, 0)) begin
        in_valid = 1'b0;
        in_prod  = 16'($urandom);
        in_last  = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_prod  = 16'(beats[i]);
      in_last  = (i == beats.size() - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Handshake the held result away; returns #1 after that edge.
  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_sum, out_count, out_ovf} !==
        {1'b1, 1'b0, 20'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%0d count=%0d ovf=%b, want 1 0 0 0 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_basic();
    beats = '{100, 200, 300};
    model();
    send_beats(0);
    checks++;
    if ({out_valid, out_sum, out_count, out_ovf} !== {1'b1, 20'd600, 16'd3, 1'b0}) begin
      errors++;
      $display("FAIL basic_600: valid=%b sum=%0d count=%0d ovf=%b, want 1 600 3 0",
               out_valid, out_sum, out_count, out_ovf);
    end
    release_result();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL basic_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_hold_stable();
    beats = '{12345};
    model();
    send_beats(0);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({in_ready, out_valid, out_sum, out_count, out_ovf} !==
          {1'b0, 1'b1, 20'd12345, 16'd1, 1'b0}) begin
        errors++;
        $display("FAIL hold_stable[%0d]: in_ready=%b valid=%b sum=%0d count=%0d ovf=%b, want 0 1 12345 1 0",
                 c, in_ready, out_valid, out_sum, out_count, out_ovf);
      end
      @(posedge clk); #1;
    end
    release_result();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_overflow();
    logic [ACC_W-1:0] want_sum;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    want_sum = 20'd1048575;
`else
    want_sum = 20'd56849;
`endif
    beats = {};
    repeat (17) beats.push_back(65025);
    model();
    send_beats(1);
    checks++;
    if ({out_valid, out_sum, out_count, out_ovf} !== {1'b1, want_sum, 16'd17, 1'b1}) begin
      errors++;
      $display("FAIL overflow_17: valid=%b sum=%0d count=%0d ovf=%b, want 1 %0d 17 1",
               out_valid, out_sum, out_count, out_ovf, want_sum);
    end
    release_result();
  endtask

  task automatic test_reset_mid_frame();
    // Two beats of an unfinished frame, then reset.
    in_valid = 1'b1; in_prod = 16'd500; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_sum, out_count, out_ovf} !==
        {1'b1, 1'b0, 20'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_frame: in_ready=%b valid=%b sum=%0d count=%0d ovf=%b, want 1 0 0 0 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    end
    @(posedge clk); #1 rst = 1'b1;
    beats = '{7};
    send_beats(0);
    checks++;
    if ({out_valid, out_sum, out_count, out_ovf} !== {1'b1, 20'd7, 16'd1, 1'b0}) begin
      errors++;
      $display("FAIL after_mid_reset: valid=%b sum=%0d count=%0d ovf=%b, want 1 7 1 0",
               out_valid, out_sum, out_count, out_ovf);
    end
    // Reset while a result is pending in HOLD drops it immediately.
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_sum, out_count, out_ovf} !==
        {1'b1, 1'b0, 20'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_in_hold: in_ready=%b valid=%b sum=%0d count=%0d ovf=%b, want 1 0 0 0 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_hold_ignore();
    beats = '{3000, 4000};
    send_beats(0);
    in_valid = 1'b1; in_prod = 16'd999; in_last = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({out_valid, out_sum, out_count, out_ovf} !== {1'b1, 20'd7000, 16'd2, 1'b0}) begin
      errors++;
      $display("FAIL hold_ignore: valid=%b sum=%0d count=%0d ovf=%b, want 1 7000 2 0",
               out_valid, out_sum, out_count, out_ovf);
    end
    release_result();
    in_valid = 1'b0; in_last = 1'b0;
    beats = '{5};
    send_beats(0);
    checks++;
    if ({out_valid, out_sum, out_count, out_ovf} !== {1'b1, 20'd5, 16'd1, 1'b0}) begin
      errors++;
      $display("FAIL hold_ignore_next: valid=%b sum=%0d count=%0d ovf=%b, want 1 5 1 0",
               out_valid, out_sum, out_count, out_ovf);
    end
    release_result();
  endtask

  // Random frames back to back: random lengths, products, idle gaps, hold
  // durations and junk on the input bus while a result is held.
  task automatic test_random();
    for (int f = 0; f < 30; f++) begin
      beats = {};
      repeat ($urandom_range(20, 1)) beats.push_back($urandom_range(65535, 0));
      model();
      send_beats((f % 3 == 0) ? 0 : 2);
      repeat ($urandom_range(3, 0)) begin
        checks++;
        if ({in_ready, out_valid, out_sum, out_count, out_ovf} !== {1'b0, 1'b1, es, ec, eo}) begin
          errors++;
          $display("FAIL random_hold[%0d]: in_ready=%b valid=%b sum=%0d count=%0d ovf=%b, want 0 1 %0d %0d %b",
                   f, in_ready, out_valid, out_sum, out_count, out_ovf, es, ec, eo);
        end
        in_valid = 1'($urandom); in_prod = 16'($urandom); in_last = 1'($urandom);
        @(posedge clk); #1;
      end
      checks++;
      if ({out_valid, out_sum, out_count, out_ovf} !== {1'b1, es, ec, eo}) begin
        errors++;
        $display("FAIL random_frame[%0d]: valid=%b sum=%0d count=%0d ovf=%b, want 1 %0d %0d %b",
                 f, out_valid, out_sum, out_count, out_ovf, es, ec, eo);
      end
      in_valid = 1'b0; in_last = 1'b0;
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_stable();
    test_overflow();
    test_reset_mid_frame();
    test_hold_ignore();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
